// File: rtl/hls_kernel_sched_pkg.sv
// Shared types and CSR map for the HLS kernel scheduler.
package hls_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, FIN} state_e;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PTR_LO = 3'd2;
  localparam logic [2:0] ADDR_PTR_HI = 3'd3;
  localparam logic [2:0] ADDR_LEN    = 3'd4;
  localparam logic [2:0] ADDR_CYCLES = 3'd5;
  localparam logic [2:0] ADDR_JOBS   = 3'd6;
  localparam logic [2:0] ADDR_ID     = 3'd7;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_TIMEOUT   = 2;
  localparam int unsigned STAT_START_ERR = 3;

endpackage

// File: rtl/hls_kernel_sched_if.sv
// Avalon-MM CSR slave bus between host interconnect and the scheduler.
interface hls_kernel_sched_if;
  logic [2:0]  slv_address;
  logic [31:0] slv_writedata;
  logic        slv_write;
  logic        slv_read;
  logic [31:0] slv_readdata;
  logic        slv_readdata_valid;
  logic        slv_waitrequest;

  modport master (
    output slv_address, slv_writedata, slv_write, slv_read,
    input  slv_readdata, slv_readdata_valid, slv_waitrequest
  );

  modport slave (
    input  slv_address, slv_writedata, slv_write, slv_read,
    output slv_readdata, slv_readdata_valid, slv_waitrequest
  );
endinterface

// File: rtl/hls_kernel_sched_csr.sv
// CSR file for the kernel scheduler: staging args, CTRL/STATUS bits, registered read mux.
module hls_sched_csr
  import hls_sched_pkg::*;
#(
  parameter logic [31:0] BLOCK_ID = 32'hAC00_0001
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  hls_kernel_sched_if.slave        slv,
  input  logic                     busy_i,
  input  logic                     done_set_i,
  input  logic                     timeout_set_i,
  input  logic                     start_err_set_i,
  input  logic [31:0]              cycles_i,
  input  logic [31:0]              jobs_i,
  output logic                     start_req_o,
  output logic [63:0]              ptr_stage_o,
  output logic [31:0]              len_stage_o,
  output logic                     irq_o
);

  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        start_err_q, start_err_d;
  logic [31:0] ptr_lo_q, ptr_lo_d;
  logic [31:0] ptr_hi_q, ptr_hi_d;
  logic [31:0] len_q, len_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [31:0] rd_mux;
  logic        wr_ctrl, wr_status;
  logic [31:0] wd;

  always_comb begin
    wd          = slv.slv_writedata;
    wr_ctrl     = slv.slv_write && (slv.slv_address == ADDR_CTRL);
    wr_status   = slv.slv_write && (slv.slv_address == ADDR_STATUS);
    start_req_o = wr_ctrl && wd[CTRL_START];

    irq_en_d = wr_ctrl ? wd[CTRL_IRQ_EN] : irq_en_q;
    // Sets from the sequencer override a same-cycle W1C.
    done_d      = done_set_i      | (done_q      & ~(wr_status & wd[STAT_DONE]));
    timeout_d   = timeout_set_i   | (timeout_q   & ~(wr_status & wd[STAT_TIMEOUT]));
    start_err_d = start_err_set_i | (start_err_q & ~(wr_status & wd[STAT_START_ERR]));

    ptr_lo_d = (slv.slv_write && slv.slv_address == ADDR_PTR_LO) ? wd : ptr_lo_q;
    ptr_hi_d = (slv.slv_write && slv.slv_address == ADDR_PTR_HI) ? wd : ptr_hi_q;
    len_d    = (slv.slv_write && slv.slv_address == ADDR_LEN)    ? wd : len_q;

    irq_d = irq_en_d & (done_d | timeout_d);

    rd_mux = '0;
    case (slv.slv_address)
      ADDR_CTRL:   rd_mux = {30'd0, irq_en_q, 1'b0};
      ADDR_STATUS: rd_mux = {28'd0, start_err_q, timeout_q, done_q, busy_i};
      ADDR_PTR_LO: rd_mux = ptr_lo_q;
      ADDR_PTR_HI: rd_mux = ptr_hi_q;
      ADDR_LEN:    rd_mux = len_q;
      ADDR_CYCLES: rd_mux = cycles_i;
      ADDR_JOBS:   rd_mux = jobs_i;
      ADDR_ID:     rd_mux = BLOCK_ID;
      default:     rd_mux = '0;
    endcase
    rdata_d = slv.slv_read ? rd_mux : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      start_err_q <= 1'b0;
      ptr_lo_q    <= '0;
      ptr_hi_q    <= '0;
      len_q       <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      start_err_q <= start_err_d;
      ptr_lo_q    <= ptr_lo_d;
      ptr_hi_q    <= ptr_hi_d;
      len_q       <= len_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= slv.slv_read;
    end
  end

  assign ptr_stage_o            = {ptr_hi_q, ptr_lo_q};
  assign len_stage_o            = len_q;
  assign irq_o                  = irq_q;
  assign slv.slv_readdata       = rdata_q;
  assign slv.slv_readdata_valid = rvalid_q;
  assign slv.slv_waitrequest    = 1'b0;

endmodule

// File: rtl/hls_kernel_sched.sv
// Sequences one HLS kernel invocation: shadow args, start handshake, run/timeout, completion.
module hls_kernel_sched
  import hls_sched_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd0,
  parameter logic [31:0] BLOCK_ID    = 32'hAC00_0001
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  hls_kernel_sched_if.slave slv,
  output logic              kern_start_o,
  input  logic              kern_busy_i,
  input  logic              kern_done_i,
  output logic              kern_stall_o,
  output logic [63:0]       ptr_o,
  output logic [31:0]       len_o,
  output logic              irq_o
);

  state_e      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] jobs_q, jobs_d;
  logic [63:0] ptr_q, ptr_d;
  logic [31:0] len_q, len_d;
  logic        start_req, done_set, timeout_set, start_err_set;
  logic [63:0] ptr_stage;
  logic [31:0] len_stage;

  always_comb begin
    state_d       = state_q;
    cycles_d      = cycles_q;
    jobs_d        = jobs_q;
    ptr_d         = ptr_q;
    len_d         = len_q;
    done_set      = 1'b0;
    timeout_set   = 1'b0;
    start_err_set = start_req && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start_req) begin
          ptr_d    = ptr_stage;
          len_d    = len_stage;
          cycles_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!kern_busy_i) state_d = RUN;
      end
      RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
        // A done on the limit cycle still completes the job normally.
        if (kern_done_i) begin
          state_d = FIN;
        end else if ((TIMEOUT_CYC != '0) && (cycles_d == TIMEOUT_CYC)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end
      end
      FIN: begin
        done_set = 1'b1;
        jobs_d   = jobs_q + 32'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      jobs_q   <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      jobs_q   <= jobs_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
    end
  end

  hls_sched_csr #(
    .BLOCK_ID(BLOCK_ID)
  ) u_csr (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .slv             (slv),
    .busy_i          (state_q != IDLE),
    .done_set_i      (done_set),
    .timeout_set_i   (timeout_set),
    .start_err_set_i (start_err_set),
    .cycles_i        (cycles_q),
    .jobs_i          (jobs_q),
    .start_req_o     (start_req),
    .ptr_stage_o     (ptr_stage),
    .len_stage_o     (len_stage),
    .irq_o           (irq_o)
  );

  assign kern_start_o = (state_q == ISSUE);
  assign kern_stall_o = 1'b0;
  assign ptr_o        = ptr_q;
  assign len_o        = len_q;

endmodule

// File: tb/tb_hls_kernel_sched.sv
// Directed bench for hls_kernel_sched with a job-level reference model checked every cycle.
module tb_hls_kernel_sched;

  localparam logic [31:0] TO_CYC = 32'd20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        kern_busy = 1'b0;
  logic        kern_done = 1'b0;
  logic        kern_start, kern_stall, irq;
  logic [63:0] ptr;
  logic [31:0] len;

  always #5 clk = ~clk;

  hls_kernel_sched_if bus();

  hls_kernel_sched #(
    .TIMEOUT_CYC(TO_CYC),
    .BLOCK_ID   (32'hAC00_0001)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .slv          (bus),
    .kern_start_o (kern_start),
    .kern_busy_i  (kern_busy),
    .kern_done_i  (kern_done),
    .kern_stall_o (kern_stall),
    .ptr_o        (ptr),
    .len_o        (len),
    .irq_o        (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int start_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is either being offered, running, or completing.
  bit        m_offer, m_running, m_completing;
  bit [31:0] m_plo, m_phi, m_len, m_cyc, m_jobs;
  bit        m_irqen, m_done, m_to, m_serr, m_irq;
  bit [63:0] m_ptr;
  bit [31:0] m_len_sh;
  bit        m_rv;
  bit [31:0] m_rd;
  bit        sw, in_job, set_done, set_to, set_serr;
  bit [31:0] wd;

  function automatic bit [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {30'd0, m_irqen, 1'b0};
      3'd1:    return {28'd0, m_serr, m_to, m_done, in_job};
      3'd2:    return m_plo;
      3'd3:    return m_phi;
      3'd4:    return m_len;
      3'd5:    return m_cyc;
      3'd6:    return m_jobs;
      3'd7:    return 32'hAC00_0001;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_offer = 0; m_running = 0; m_completing = 0;
      m_plo = 0; m_phi = 0; m_len = 0; m_cyc = 0; m_jobs = 0;
      m_irqen = 0; m_done = 0; m_to = 0; m_serr = 0; m_irq = 0;
      m_ptr = 0; m_len_sh = 0; m_rv = 0; m_rd = 0;
    end else begin
      in_job = m_offer || m_running || m_completing;
      wd     = bus.slv_writedata;
      m_rv   = bus.slv_read;
      m_rd   = bus.slv_read ? m_read(bus.slv_address) : 32'd0;
      sw     = bus.slv_write && bus.slv_address == 3'd0 && wd[0];
      set_done = 0; set_to = 0; set_serr = sw && in_job;

      if (m_completing) begin
        m_completing = 0; set_done = 1; m_jobs = m_jobs + 1;
      end else if (m_running) begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (kern_done) begin
          m_running = 0; m_completing = 1;
        end else if (m_cyc == TO_CYC) begin
          m_running = 0; set_to = 1;
        end
      end else if (m_offer) begin
        if (!kern_busy) begin m_offer = 0; m_running = 1; end
      end else if (sw) begin
        m_ptr = {m_phi, m_plo}; m_len_sh = m_len; m_cyc = 0; m_offer = 1;
      end

      if (bus.slv_write) begin
        case (bus.slv_address)
          3'd0: m_irqen = wd[1];
          3'd1: begin
            if (wd[1]) m_done = 0;
            if (wd[2]) m_to = 0;
            if (wd[3]) m_serr = 0;
          end
          3'd2: m_plo = wd;
          3'd3: m_phi = wd;
          3'd4: m_len = wd;
          default: ;
        endcase
      end
      if (set_done) m_done = 1;
      if (set_to)   m_to = 1;
      if (set_serr) m_serr = 1;
      m_irq = m_irqen && (m_done || m_to);
    end
  end

  always @(negedge clk) begin
    check("kern_start_o", kern_start, m_offer);
    if (kern_start) start_hi = start_hi + 1;
    check("ptr_o", ptr, m_ptr);
    check("len_o", len, m_len_sh);
    check("irq_o", irq, m_irq);
    check("readdata_valid", bus.slv_readdata_valid, m_rv);
    if (m_rv) check("readdata", bus.slv_readdata, m_rd);
    check("stall_waitreq", {kern_stall, bus.slv_waitrequest}, 2'b00);
  end

  // All tasks start and end right after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.slv_address = a; bus.slv_writedata = d; bus.slv_write = 1'b1;
    @(negedge clk);
    bus.slv_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus.slv_address = a; bus.slv_read = 1'b1;
    @(negedge clk);
    bus.slv_read = 1'b0;
    check({name, "_valid"}, bus.slv_readdata_valid, 1'b1);
    check(name, bus.slv_readdata, exp);
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    bus.slv_address = a; bus.slv_writedata = d; bus.slv_write = 1'b1; bus.slv_read = 1'b1;
    @(negedge clk);
    bus.slv_write = 1'b0; bus.slv_read = 1'b0;
    check(name, bus.slv_readdata, exp);
  endtask

  int s0;

  initial begin
    bus.slv_address = 3'd0; bus.slv_writedata = 32'd0;
    bus.slv_write = 1'b0; bus.slv_read = 1'b0;
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    // Reset state and ID read with fixed latency
    check("rst_start", kern_start, 1'b0);
    check("rst_ptr", ptr, 64'd0);
    check("rst_irq", irq, 1'b0);
    rd(3'd7, 32'hAC00_0001, "id");
    cyc(1);
    check("id_valid_one_cycle", bus.slv_readdata_valid, 1'b0);
    rd(3'd1, 32'd0, "status_rst");

    // Basic job: done 10 cycles after handshake
    wr(3'd2, 32'h0000_1000); wr(3'd3, 32'h1); wr(3'd4, 32'd256);
    s0 = start_hi;
    wr(3'd0, 32'h1);
    check("start_latency", kern_start, 1'b1);
    cyc(1);
    check("ptr_basic", ptr, 64'h1_0000_1000);
    check("len_basic", len, 64'd256);
    cyc(9); kern_done = 1'b1; cyc(1); kern_done = 1'b0; cyc(1);
    check("start_pulses_basic", start_hi - s0, 64'd1);
    rd(3'd1, 32'h2, "status_done");
    rd(3'd5, 32'd10, "cycles_basic");
    rd(3'd6, 32'd1, "jobs_basic");
    rw(3'd4, 32'h80, 32'd256, "rw_pre_write");
    rd(3'd4, 32'h80, "len_after_rw");
    wr(3'd1, 32'h2);
    rd(3'd1, 32'h0, "status_w1c_done");

    // Backpressure: busy for 5 cycles after START
    kern_busy = 1'b1;
    s0 = start_hi;
    wr(3'd0, 32'h1);
    cyc(5); kern_busy = 1'b0;
    cyc(3); kern_done = 1'b1; cyc(1); kern_done = 1'b0; cyc(1);
    check("start_pulses_busy", start_hi - s0, 64'd6);
    rd(3'd5, 32'd3, "cycles_busy");
    rd(3'd6, 32'd2, "jobs_busy");

    // START while running plus staging write
    wr(3'd1, 32'h2);
    s0 = start_hi;
    wr(3'd0, 32'h1);
    cyc(3);
    wr(3'd2, 32'h0000_2000);
    wr(3'd0, 32'h1);
    rd(3'd1, 32'h9, "status_serr_busy");
    check("ptr_unchanged", ptr, 64'h1_0000_1000);
    kern_done = 1'b1; cyc(1); kern_done = 1'b0; cyc(1);
    check("start_pulses_serr", start_hi - s0, 64'd1);
    rd(3'd1, 32'hA, "status_done_serr");
    wr(3'd1, 32'h8);
    rd(3'd1, 32'h2, "status_w1c_serr");
    rd(3'd6, 32'd3, "jobs_serr");

    // Timeout with IRQ enabled, then a late done
    wr(3'd1, 32'hE);
    wr(3'd0, 32'h2);
    wr(3'd0, 32'h3);
    cyc(1);
    check("ptr_second_job", ptr, 64'h1_0000_2000);
    cyc(24);
    check("irq_timeout", irq, 1'b1);
    rd(3'd1, 32'h4, "status_timeout");
    rd(3'd5, TO_CYC, "cycles_timeout");
    kern_done = 1'b1; cyc(1); kern_done = 1'b0; cyc(2);
    rd(3'd6, 32'd3, "jobs_late_done");
    rd(3'd1, 32'h4, "status_late_done");

    // Asynchronous reset during RUN
    wr(3'd0, 32'h3);
    cyc(3);
    check("irq_before_rst", irq, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_start", kern_start, 1'b0);
    check("arst_ptr", ptr, 64'd0);
    check("arst_irq", irq, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    rd(3'd1, 32'h0, "status_after_rst");

    // Asynchronous reset while offering the call
    kern_busy = 1'b1;
    wr(3'd0, 32'h1);
    check("issue_before_rst", kern_start, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_issue_start", kern_start, 1'b0);
    @(negedge clk); rst_n = 1'b1; kern_busy = 1'b0;

    // Fresh job after reset
    wr(3'd2, 32'h0000_3000); wr(3'd4, 32'd64);
    wr(3'd0, 32'h1);
    cyc(1);
    check("ptr_fresh", ptr, 64'h0000_3000);
    cyc(3); kern_done = 1'b1; cyc(1); kern_done = 1'b0; cyc(1);
    rd(3'd1, 32'h2, "status_fresh");
    rd(3'd5, 32'd4, "cycles_fresh");
    rd(3'd6, 32'd1, "jobs_fresh");
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
